// File: rtl/seq_alu_if.sv
// Execute-stage ALU bus: operation request from ID/EX, registered result to EX/MEM.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      ALUCtrl_i;
  logic [XLEN-1:0] data1_i;
  logic [XLEN-1:0] data2_i;
  logic            flush_i;
  logic            ready_o;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] data_o;
  logic            zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  ready_o, stall_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output ready_o, stall_o, valid_o, data_o, zero_o
  );
endinterface

// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/XOR/SLL/SRA with a registered
// result, plus an iterative shift-add MUL (XLEN iterations) that stalls the pipe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a new operation; single-cycle ops complete here
// MUL_BUSY | shift-add multiply in progress, one multiplier bit per cycle
module seq_alu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk_i,
  input  logic      rst_i,
  seq_alu_if.slave  bus
);

  // ALU control encodings (match ALU_CONTROL_CONSTANT_* in const.v); 3'b111 is unused
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   acc_q;
  logic [XLEN-1:0]   data_q;
  logic              zero_q;
  logic              valid_q;

  logic              ready;
  logic              stall;
  logic              accept;
  logic              is_mul;
  logic              mul_step;
  logic              mul_last;
  logic [XLEN-1:0]   acc_sum;
  logic [XLEN-1:0]   alu_res;

  assign is_mul   = (bus.ALUCtrl_i == ALU_MUL);
  assign accept   = ready && bus.valid_i && !bus.flush_i;
  assign mul_step = (state_q == MUL_BUSY) && !bus.flush_i;
  assign mul_last = mul_step && (cnt_q == CNT_LAST);
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle operation result; unused codes fall back to ADD
  always_comb begin
    alu_res = bus.data1_i + bus.data2_i;
    case (bus.ALUCtrl_i)
      ALU_SUB: alu_res = bus.data1_i - bus.data2_i;
      ALU_AND: alu_res = bus.data1_i & bus.data2_i;
      ALU_XOR: alu_res = bus.data1_i ^ bus.data2_i;
      ALU_SLL: alu_res = bus.data1_i << bus.data2_i[4:0];
      ALU_SRA: alu_res = $signed(bus.data1_i) >>> bus.data2_i[4:0];
      default: alu_res = bus.data1_i + bus.data2_i;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
      MUL_BUSY: if (bus.flush_i || mul_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: ready and stall are combinational on state and request
  always_comb begin
    ready = (state_q == IDLE);
    stall = mul_step || (ready && bus.valid_i && is_mul && !bus.flush_i);
  end

  // Multiplier datapath, iteration counter and registered result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand_q  <= bus.data1_i;
          mplier_q <= bus.data2_i;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else begin
          data_q  <= alu_res;
          zero_q  <= (alu_res == '0);
          valid_q <= 1'b1;
        end
      end else if (state_q == MUL_BUSY) begin
        if (bus.flush_i) begin
          cnt_q <= '0;
        end else begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (mul_last) begin
            cnt_q   <= '0;
            data_q  <= acc_sum;
            zero_q  <= (acc_sum == '0);
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.stall_o = stall;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Execute-stage datapath unit that consumes the 3-bit ALU control code produced by ALU_Control, together with the two operands from the ID/EX register.
- ADD, SUB, AND, XOR, SLL and SRA complete in one cycle with a registered result.
- MUL runs as an iterative shift-add multiplier over XLEN cycles and holds the pipeline through stall_o.
- The registered result feeds the EX/MEM register and branch logic (zero_o).

Parameters:
XLEN, 32, operand/result width; also the MUL iteration count
CNT_W, 6, width of the MUL iteration counter; must satisfy 2^CNT_W > XLEN

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
valid_i  input  1  operation present on the inputs this cycle
ALUCtrl_i  input  3  operation code; values are the ALU_CONTROL_CONSTANT_* definitions in const.v
data1_i  input  XLEN  operand A (rs1)
data2_i  input  XLEN  operand B (rs2 or immediate)
flush_i  input  1  abort any in-flight or just-presented operation
ready_o  output  1  unit can accept an operation this cycle
stall_o  output  1  upstream pipeline must hold its registers this cycle
valid_o  output  1  one-cycle pulse: data_o/zero_o updated with a new result
data_o  output  XLEN  registered result
zero_o  output  1  registered flag, data_o == 0

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, counter=0, internal regs=0; data_o=0, zero_o=1, valid_o=0. Outputs after reset: ready_o=1, stall_o=0. rst_i has priority over every other input, including mid-MUL (result discarded, no valid_o).
- Clocking: clk_i only; reset is synchronous, active-high.
- States: IDLE, MUL_BUSY.
- ready_o = (state==IDLE). This output is combinational.
- stall_o = (state==MUL_BUSY && !flush_i) || (state==IDLE && valid_i && ALUCtrl_i==MUL && !flush_i). This output is combinational.
- Accept: an operation is accepted at an edge where state==IDLE, valid_i=1 and flush_i=0.
- Single-cycle ops, applied at the accept edge:
  - data_o <= f(data1_i, data2_i); zero_o <= (f==0); valid_o <= 1.
  - Latency is 1; back-to-back accepts every cycle are allowed.
- Operation semantics:
  - ADD: a+b, modulo 2^XLEN.
  - SUB: a-b, modulo 2^XLEN.
  - AND: a&b.
  - XOR: a^b.
  - SLL: a << b[4:0].
  - SRA: signed a >>> b[4:0], sign-filled.
  - Undefined or unused codes behave as ADD.
- MUL accept edge: mcand <= data1_i, mplier <= data2_i, acc <= 0, counter <= 0, state <= MUL_BUSY, valid_o <= 0.
- Each MUL_BUSY edge (no flush, no reset):
  - if mplier[0]: acc += mcand (mod 2^XLEN);
  - then mcand <<= 1, mplier >>= 1 (logical), counter++.
- MUL completion: the edge where counter==XLEN-1 performs the last iteration and also writes data_o <= final acc and zero_o <= (final acc==0). It sets valid_o <= 1 and state <= IDLE.
  - Result = low XLEN bits of the product; this is identical for signed and unsigned operands.
  - MUL latency: valid_o is high exactly XLEN+1 cycles after the accept cycle.
  - stall_o falls in the same cycle valid_o rises.
- valid_o is a one-cycle pulse. It is 0 at any edge without an accept or MUL completion. data_o and zero_o hold their last value between results.
- valid_i during MUL_BUSY is ignored; upstream is stalled and must hold the instruction.
- flush_i:
  - In IDLE it suppresses the accept: no state change, valid_o <= 0.
  - In MUL_BUSY it forces state <= IDLE and counter <= 0. No valid_o is produced and data_o is unchanged.
  - A flush on the completion edge also suppresses the result.
- Counter wrap: the counter never exceeds XLEN-1 and is cleared on every MUL accept.

Test Plan:
- Reset: hold rst_i 2 cycles with valid_i=1, ADD, 5, 6 -> data_o=0, zero_o=1, valid_o=0, ready_o=1, stall_o=0.
- Single-cycle ops, back-to-back on 6 consecutive cycles:
  - ADD 0xFFFFFFFF+1 -> 0, zero_o=1;
  - SUB 3-5 -> 0xFFFFFFFE;
  - AND 0xF0F0,0xFF00 -> 0xF000;
  - XOR 0xAAAA,0xFFFF -> 0x5555;
  - SLL 1,0x21 -> 2 (only b[4:0] used);
  - SRA 0x80000000,4 -> 0xF8000000.
  - Expect valid_o high each cycle, 1-cycle latency.
- MUL 7 × 0xFFFFFFFD (-3):
  - stall_o=1 in the accept cycle and for the following 32 cycles;
  - valid_o pulses exactly 33 cycles after accept with data_o=0xFFFFFFEB, zero_o=0;
  - ready_o=0 throughout.
- MUL overflow: 0x00010000 × 0x00010000 -> data_o=0, zero_o=1 at cycle 33. A valid_i ADD held during busy is accepted only after ready_o returns.
- Flush: MUL 9×9, assert flush_i at busy cycle 10 -> ready_o=1 next cycle, no valid_o, data_o unchanged. A subsequent MUL 9×9 yields 81.
- Reset mid-MUL: rst_i at busy cycle 20 -> state IDLE, data_o=0, no valid_o pulse afterwards.
